// File: rtl/input_sync_pkg.sv
// ============================================================================
// input_sync_pkg : shared limits, defaults and word type for input_synchronizer
// Revision: 1.0
// ============================================================================
`default_nettype none

package input_sync_pkg;

  localparam int SYNC_STAGES_MIN    = 2;
  localparam int SYNC_STAGES_MAX    = 4;
  localparam int DATA_WIDTH_DEFAULT = 8;

  typedef logic [DATA_WIDTH_DEFAULT-1:0] sync_word_t;

  function automatic bit stages_legal(input int n);
    return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_cell.sv
// ============================================================================
// sync_cell : single-bit flop chain with asynchronous reset
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_cell #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  // Keep the chain tightly placed and excluded from retiming.
  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], async_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/input_synchronizer.sv
// ============================================================================
// input_synchronizer : per-bit multi-flop synchronizer for asynchronous inputs,
// with optional rise/fall pulse outputs when INPUT_SYNC_EDGE_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module input_synchronizer
  import input_sync_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DATA_WIDTH_DEFAULT,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
`ifdef INPUT_SYNC_EDGE_EN
  ,
  output logic [DATA_WIDTH-1:0] rise,
  output logic [DATA_WIDTH-1:0] fall
`endif
);

  if (!stages_legal(SYNC_STAGES)) begin : g_bad_stages
    $error("input_synchronizer: SYNC_STAGES must be within 2..4");
  end

  // Bits are synchronized independently; no cross-bit coherency.
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
    sync_cell #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VALUE (RESET_VALUE[i])
    ) u_sync_cell (
      .clk     (clk),
      .rst     (rst),
      .async_i (data_in[i]),
      .sync_o  (data_out[i])
    );
  end

`ifdef INPUT_SYNC_EDGE_EN
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] rise_q;
  logic [DATA_WIDTH-1:0] fall_q;
  logic [DATA_WIDTH-1:0] rise_d;
  logic [DATA_WIDTH-1:0] fall_d;

  assign rise_d = data_out & ~prev_q;
  assign fall_d = ~data_out & prev_q;

  // prev_q resets to RESET_VALUE so no spurious pulse follows reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= RESET_VALUE;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      prev_q <= data_out;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_input_synchronizer.sv
// ============================================================================
// tb_input_synchronizer : scoreboard bench for input_synchronizer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_input_synchronizer;
  import input_sync_pkg::*;

  localparam int             W  = DATA_WIDTH_DEFAULT;
  localparam int             S  = 2;
  localparam logic [W-1:0]   RV = '0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  sync_word_t data_in = '0;
  sync_word_t data_out;
`ifdef INPUT_SYNC_EDGE_EN
  sync_word_t rise;
  sync_word_t fall;
`endif

  input_synchronizer #(
    .DATA_WIDTH  (W),
    .SYNC_STAGES (S),
    .RESET_VALUE (RV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .data_out (data_out)
`ifdef INPUT_SYNC_EDGE_EN
    ,
    .rise     (rise),
    .fall     (fall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: data_out after an edge is the input sampled S-1 edges earlier.
  initial begin
    logic [W-1:0] hist[$];
    logic [W-1:0] last1, last2;
    exp_t         e;
    last1 = RV;
    last2 = RV;
    forever begin
      @(posedge clk);
      if (rst) begin
        hist.delete();
        e.out  = RV;
        e.rise = '0;
        e.fall = '0;
        last1  = RV;
        last2  = RV;
      end else begin
        hist.push_back(data_in);
        e.out  = (hist.size() > S - 1) ? hist[hist.size() - S] : RV;
        e.rise = last1 & ~last2;
        e.fall = ~last1 & last2;
        if (hist.size() > 8) void'(hist.pop_front());
        last2 = last1;
        last1 = e.out;
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: every cycle presents an output; compare away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: got empty queue, expected an entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("data_out", data_out, e.out);
`ifdef INPUT_SYNC_EDGE_EN
        check("rise", rise, e.rise);
        check("fall", fall, e.fall);
`endif
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic mid();
    @(posedge clk);
    #3;
  endtask

  initial begin
    logic [W-1:0] seq[3];
    logic [W-1:0] n_rise, n_fall;
    int           mode;
    seq[0] = 8'h55;
    seq[1] = 8'hF0;
    seq[2] = 8'h0F;

    #20;
    check("reset_hold", data_out, 8'h00);
    data_in = 8'hAA;
    mid();
    check("reset_aa", data_out, 8'h00);
    data_in = 8'h00;
    rst     = 1'b0;

    mid();
    data_in = 8'hAA;
    mid();
    check("latency_early", data_out, 8'h00);
    mid();
    check("latency", data_out, 8'hAA);

    for (int k = 0; k < 3; k++) begin
      data_in = seq[k];
      repeat (3) mid();
      check("sequence", data_out, seq[k]);
    end

    mid();
    data_in = 8'h11; #2;
    data_in = 8'h22; #2;
    data_in = 8'h33; #2;
    data_in = 8'h44;
    repeat (3) mid();
    check("toggle_settle", data_out, 8'h44);
    repeat (2) mid();
    check("toggle_hold", data_out, 8'h44);

`ifdef INPUT_SYNC_EDGE_EN
    data_in = 8'h0F;
    repeat (4) mid();
    data_in = 8'hF0;
    n_rise = '0;
    n_fall = '0;
    repeat (6) begin
      mid();
      if (rise == 8'hF0) n_rise++;
      if (fall == 8'h0F) n_fall++;
    end
    check("rise_pulses", n_rise, 8'd1);
    check("fall_pulses", n_fall, 8'd1);
    check("rise_idle", rise, 8'h00);
`endif

    repeat (150) begin
      mid();
      mode = $urandom_range(0, 3);
      if (mode == 1 || mode == 2) begin
        data_in = W'($urandom);
      end else if (mode == 3) begin
        data_in = W'($urandom); #2;
        data_in = W'($urandom); #2;
        data_in = W'($urandom);
      end
    end

    mid();
    data_in = 8'hFF;
    #1 rst = 1'b1;
    #1 check("async_rst", data_out, 8'h00);
    repeat (2) mid();
    check("async_rst_hold", data_out, 8'h00);
    rst = 1'b0;

    repeat (50) begin
      mid();
      data_in = W'($urandom);
    end
    repeat (4) mid();
    check("final_settle", data_out, data_in);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
